bpu_gshare: RTL

- Parametrised branch-prediction unit for the 5-stage RV32I pipeline; generalises the fixed 10-bit pattern path into a configurable predictor.
- In IF, it performs a combinational lookup of a BTB and a pattern history table (PHT) of 2-bit counters. It returns the predicted direction, the predicted target, and the PHT index (pattern) that travels down the pipe.
- In EX, it takes the resolved outcome, reports a mispredict with the redirect PC, and updates the PHT, global history register (GHR), BTB and statistics counters on the clock edge.

---
 rtl/bpu_gshare.sv | 132 +++++++++++++
 1 files changed

// File: rtl/bpu_gshare.sv
// Branch predictor for IF/EX: a BTB plus a PHT of 2-bit counters, indexed bimodally or by gshare.
// Lookup and resolve are combinational with zero latency, training commits on the clock edge, and the unit never stalls.
module bpu_gshare #(
   parameter int PC_W      = 32,
   parameter int GHR_W     = 10,
   parameter int BTB_DEPTH = 64,
   parameter int MODE      = 2
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [PC_W-1:0]   i_pc_F,
   output logic              o_pred_taken_F,
   output logic [PC_W-1:0]   o_pred_target_F,
   output logic [GHR_W-1:0]  o_pattern_F,
   input  logic              i_resolve_vld_E,
   input  logic              i_is_jump_E,
   input  logic [PC_W-1:0]   i_pc_E,
   input  logic              i_taken_E,
   input  logic [PC_W-1:0]   i_target_E,
   input  logic [GHR_W-1:0]  i_pattern_E,
   input  logic              i_pred_taken_E,
   input  logic [PC_W-1:0]   i_pred_target_E,
   output logic              o_mispredict_E,
   output logic [PC_W-1:0]   o_redirect_pc_E,
   output logic [31:0]       o_branch_cnt,
   output logic [31:0]       o_mispred_cnt
);

   localparam int BIDX_W = $clog2(BTB_DEPTH);
   localparam int TAG_W  = PC_W - BIDX_W - 2;
   localparam int PHT_D  = 1 << GHR_W;

   logic [GHR_W-1:0]  ghr_q, ghr_d;
   logic [1:0]        pht_q [PHT_D];
   logic [1:0]        pht_d;
   logic              btb_vld_q [BTB_DEPTH];
   logic [TAG_W-1:0]  btb_tag_q [BTB_DEPTH];
   logic [PC_W-1:0]   btb_tgt_q [BTB_DEPTH];
   logic              btb_jmp_q [BTB_DEPTH];
   logic [31:0]       br_cnt_q, br_cnt_d;
   logic [31:0]       mp_cnt_q, mp_cnt_d;

   logic [GHR_W-1:0]  f_pattern;
   logic [BIDX_W-1:0] f_bidx;
   logic              f_hit;
   logic              f_taken;
   logic [BIDX_W-1:0] e_bidx;
   logic              e_mispredict;
   logic [1:0]        e_pht_cur;

   always_comb begin
      f_pattern = i_pc_F[GHR_W+1:2];
      if (MODE == 2) begin
         f_pattern = i_pc_F[GHR_W+1:2] ^ ghr_q;
      end
      f_bidx  = i_pc_F[BIDX_W+1:2];
      f_hit   = btb_vld_q[f_bidx] && (btb_tag_q[f_bidx] == i_pc_F[PC_W-1:BIDX_W+2]);
      f_taken = (MODE != 0) && f_hit && (btb_jmp_q[f_bidx] || pht_q[f_pattern][1]);

      // Outputs are forced to zero for as long as reset is held.
      o_pred_taken_F  = i_rst && f_taken;
      o_pred_target_F = '0;
      o_pattern_F     = '0;
      if (i_rst) begin
         o_pred_target_F = f_taken ? btb_tgt_q[f_bidx] : i_pc_F + PC_W'(4);
         o_pattern_F     = f_pattern;
      end
   end

   always_comb begin
      e_bidx       = i_pc_E[BIDX_W+1:2];
      e_mispredict = i_resolve_vld_E &&
                     ((i_taken_E != i_pred_taken_E) ||
                      (i_taken_E && (i_target_E != i_pred_target_E)));
      o_mispredict_E  = i_rst && e_mispredict;
      o_redirect_pc_E = '0;
      if (i_rst && i_resolve_vld_E) begin
         o_redirect_pc_E = i_taken_E ? i_target_E : i_pc_E + PC_W'(4);
      end
   end

   always_comb begin
      e_pht_cur = pht_q[i_pattern_E];
      pht_d     = e_pht_cur;
      if (i_taken_E && (e_pht_cur != 2'd3)) begin
         pht_d = e_pht_cur + 2'd1;
      end else if (!i_taken_E && (e_pht_cur != 2'd0)) begin
         pht_d = e_pht_cur - 2'd1;
      end
      ghr_d    = {ghr_q[GHR_W-2:0], i_taken_E};
      br_cnt_d = (&br_cnt_q) ? br_cnt_q : br_cnt_q + 32'd1;
      mp_cnt_d = mp_cnt_q;
      if (e_mispredict && !(&mp_cnt_q)) begin
         mp_cnt_d = mp_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         ghr_q    <= '0;
         br_cnt_q <= '0;
         mp_cnt_q <= '0;
         for (int i = 0; i < PHT_D; i++) begin
            pht_q[i] <= 2'b01;
         end
         for (int i = 0; i < BTB_DEPTH; i++) begin
            btb_vld_q[i] <= 1'b0;
            btb_tag_q[i] <= '0;
            btb_tgt_q[i] <= '0;
            btb_jmp_q[i] <= 1'b0;
         end
      end else if (i_resolve_vld_E) begin
         // Training always uses the pattern carried from fetch, never a recomputed index.
         if (!i_is_jump_E) begin
            pht_q[i_pattern_E] <= pht_d;
            ghr_q              <= ghr_d;
         end
         if (i_taken_E) begin
            btb_vld_q[e_bidx] <= 1'b1;
            btb_tag_q[e_bidx] <= i_pc_E[PC_W-1:BIDX_W+2];
            btb_tgt_q[e_bidx] <= i_target_E;
            btb_jmp_q[e_bidx] <= i_is_jump_E;
         end
         br_cnt_q <= br_cnt_d;
         mp_cnt_q <= mp_cnt_d;
      end
   end

   assign o_branch_cnt  = br_cnt_q;
   assign o_mispred_cnt = mp_cnt_q;

endmodule
